// File: rtl/skid_buffer_sync_pkg.sv
// Shared types for the two-entry skid buffer: FSM state encoding and occupancy width.
package skid_pkg;

   localparam int COUNT_W = 2;

   // Encodings equal the number of words held, so occupancy decodes directly from state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   function automatic logic [COUNT_W-1:0] state_count(input state_t s);
      case (s)
         BUSY:    return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/skid_buffer_sync_if.sv
// Producer-side and consumer-side valid/ready handshake bundle for the skid buffer.
interface skid_buffer_sync_if #(
   parameter int WIDTH = 8
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   // slave: the buffer's view; master: the surrounding producer/consumer view.
   modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
   modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/skid_buffer_sync_data_reg_en.sv
// WIDTH-bit register with load enable; async active-low reset clears it to zero.
module data_reg_en #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/skid_buffer_sync.sv
// Two-entry skid buffer: one-cycle latency, full throughput, s_ready decoded from state flops only.
// Flush empties the buffer with priority over push/pop; data registers hold stale contents.
module skid_buffer_sync
   import skid_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   skid_buffer_sync_if.slave  bus,
   output logic [COUNT_W-1:0] count
);

   state_t           state;
   logic             push;
   logic             pop;
   logic             main_ld;
   logic             skid_ld;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   assign push = bus.s_valid & bus.s_ready;
   assign pop  = bus.m_valid & bus.m_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: if (push) state <= BUSY;
            BUSY: begin
               if (push && !pop)      state <= FULL;
               else if (pop && !push) state <= EMPTY;
            end
            FULL:  if (pop) state <= BUSY;
            default: state <= EMPTY;
         endcase
      end
   end

   // main refills from skid only when draining FULL; skid is always the younger word.
   always_comb begin
      main_ld = 1'b0;
      skid_ld = 1'b0;
      main_d  = bus.s_data;
      if (!flush) begin
         case (state)
            EMPTY: main_ld = push;
            BUSY: begin
               main_ld = push & pop;
               skid_ld = push & ~pop;
            end
            FULL: begin
               main_ld = pop;
               main_d  = skid_q;
            end
            default: ;
         endcase
      end
   end

   data_reg_en #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .rst_n (reset),
      .en    (main_ld),
      .d     (main_d),
      .q     (main_q)
   );

   data_reg_en #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .rst_n (reset),
      .en    (skid_ld),
      .d     (bus.s_data),
      .q     (skid_q)
   );

   assign bus.m_data  = main_q;
   assign bus.m_valid = (state != EMPTY);
   assign bus.s_ready = (state != FULL) & reset;
   assign count       = state_count(state);

endmodule

// File: tb/tb_skid_buffer_sync.sv
// Directed and random stimulus for skid_buffer_sync against a queue scoreboard.
module tb_skid_buffer_sync;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic [1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q[$];
   logic       held_vld = 1'b0;
   logic [7:0] held_dat;

   skid_buffer_sync_if #(.WIDTH(8)) bus ();

   skid_buffer_sync #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, check outputs, update the model, advance.
   task automatic step(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
      logic push;
      logic pop;
      bus.s_valid = sv;
      bus.s_data  = sd;
      bus.m_ready = mr;
      flush       = fl;
      #1;
      check("count",   32'(count),       32'(q.size()));
      check("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      check("s_ready", 32'(bus.s_ready), 32'(q.size() < 2));
      if (held_vld) check("stall_stable", 32'(bus.m_data), 32'(held_dat));
      push = sv && bus.s_ready;
      pop  = bus.m_valid && mr;
      if (pop && q.size() != 0) check("m_data", 32'(bus.m_data), 32'(q.pop_front()));
      held_vld = bus.m_valid && !mr && !fl;
      held_dat = bus.m_data;
      if (fl) q.delete();
      else if (push) q.push_back(sd);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b0;
      flush       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.m_ready = 1'b0;

      // Held in reset
      repeat (2) @(negedge clk);
      check("rst_s_ready", 32'(bus.s_ready), 32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_count",   32'(count),       32'd0);
      check("rst_m_data",  32'(bus.m_data),  32'd0);
      reset = 1'b1;
      #1;
      check("rel_s_ready", 32'(bus.s_ready), 32'd1);
      check("rel_m_data",  32'(bus.m_data),  32'd0);
      @(negedge clk);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Streaming at full rate
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Backpressure: A3 must be held by the producer until space opens
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 8'hA3, 1'b0, 1'b0);
      check("bp_full_count", 32'(count), 32'd2);
      check("bp_s_ready",    32'(bus.s_ready), 32'd0);
      check("bp_main",       32'(bus.m_data), 32'hA1);
      step(1'b1, 8'hA3, 1'b1, 1'b0);
      step(1'b1, 8'hA3, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("bp_drained", 32'(q.size()), 32'd0);

      // Flush colliding with a push while FULL
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b1, 1'b1);
      check("fl_count",   32'(count),       32'd0);
      check("fl_m_valid", 32'(bus.m_valid), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h44, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset asserted between edges while FULL
      step(1'b1, 8'h55, 1'b0, 1'b0);
      step(1'b1, 8'h66, 1'b0, 1'b0);
      bus.s_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("mr_m_valid", 32'(bus.m_valid), 32'd0);
      check("mr_count",   32'(count),       32'd0);
      check("mr_s_ready", 32'(bus.s_ready), 32'd0);
      check("mr_m_data",  32'(bus.m_data),  32'd0);
      q.delete();
      held_vld = 1'b0;
      #1 reset = 1'b1;
      @(negedge clk);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      check("mr_first", 32'(bus.m_data), 32'h5A);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic at ~50% valid/ready
      for (int i = 0; i < 10000; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      check("final_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/skid_buffer_sync.md
# skid_buffer_sync

Two-entry valid/ready skid buffer that sits directly upstream of a plain pipeline register stage in the accelerator datapath. It accepts a WIDTH-bit word per cycle from a producer and presents it to a consumer with full throughput. `s_ready` is decoded from state flops only, which breaks the combinational ready path between consumer and producer. The buffer never drops or duplicates a word except on an explicit flush.

## Interface
- WIDTH, 8, data word width in bits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; asserted when 0
- flush  input  1  synchronous clear of buffered contents, active-high
- s_valid  input  1  producer word valid
- s_ready  output  1  buffer can accept a word this cycle
- s_data  input  WIDTH  producer word
- m_valid  output  1  consumer word valid
- m_ready  input  1  consumer accepts the word this cycle
- m_data  output  WIDTH  consumer word
- count  output  2  occupancy: 0, 1 or 2

## Operation
- One clock and one reset: `clk`, and `reset`, which is asynchronous and active-low.
- Storage: `main` register drives `m_data`. `skid` register holds an overflow word.
- Push = s_valid & s_ready. Pop = m_valid & m_ready.
- States:
  - EMPTY: count 0, m_valid 0, s_ready 1.
  - BUSY: count 1, m_valid 1, s_ready 1.
  - FULL: count 2, m_valid 1, s_ready 0.
- EMPTY: push -> main<=s_data, go to BUSY. Otherwise stay.
- BUSY:
  - push & pop -> main<=s_data, stay BUSY.
  - push & !pop -> skid<=s_data, go to FULL.
  - pop & !push -> go to EMPTY.
  - neither -> stay.
- FULL: pop -> main<=skid, go to BUSY. Push is impossible because s_ready is 0.
- Output decode:
  - s_ready = (state != FULL) & reset deasserted.
  - m_valid = (state != EMPTY).
  - No combinational path from m_ready to s_ready.
- flush has priority over push and pop in the same cycle:
  - Next state is EMPTY; any concurrent push is discarded.
  - Data registers keep their contents and are don't-care while EMPTY.
- Order is strictly FIFO: the skid word is always younger than the main word.
- m_data is stable while m_valid=1 and m_ready=0.

## Timing
- Reset (asynchronous assertion):
  - state=EMPTY, main=0, skid=0.
  - m_valid=0, m_data=0, count=0.
  - s_ready=0 while reset is asserted. s_ready=1 immediately after release.
- Reset is allowed mid-operation and discards both entries without an output glitch beyond going invalid.
- Latency: a word pushed at edge N is visible on m_data/m_valid after edge N (one cycle).
- Throughput: with m_ready held 1, one word per cycle is sustained indefinitely and the state never leaves BUSY.
- s_ready falls in the cycle after a push meets m_ready=0 while BUSY. It rises in the cycle after a pop while FULL.
- count changes in the same cycle as the state flops.

## Structure
- Shared package `skid_pkg`:
  - state typedef: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
  - count width constant: 2.
- Natural sub-module `data_reg_en`: a WIDTH-bit register with load enable and asynchronous active-low reset to zero. Instantiated twice (main, skid).
- Load-select mux for main (s_data vs skid) and the FSM live in the top module.

## Test plan
- Reset release, idle: after reset rises, s_ready=1, m_valid=0, count=0, m_data=0.
- Streaming: push 0x01..0x10 on consecutive cycles with m_ready=1 -> m_data shows 0x01..0x10 one cycle later each, count stays 1, s_ready never drops.
- Backpressure:
  - Stimulus: push 0xA1, 0xA2, 0xA3 with m_ready=0.
  - Response: 0xA1 and 0xA2 accepted, count=2, s_ready=0, 0xA3 held by producer.
  - Then raise m_ready: outputs 0xA1, 0xA2, 0xA3 in order, none lost or duplicated.
- Flush collision: FULL holding 0x11/0x22, assert flush with s_valid=1, s_data=0x33, m_ready=1 -> next cycle EMPTY, count=0, m_valid=0, 0x33 not delivered.
- Reset mid-operation: FULL, assert reset asynchronously between edges -> m_valid and count go 0 at once. After release, the first output is the first new push.
- Random: random s_valid/m_ready at 50% for 10k cycles against a scoreboard -> exact in-order match, m_data stable under stall, count never exceeds 2.
